// File: rtl/hpf_dp_arbiter_pkg.sv
// Shared definitions for the HPF datapath arbiter: FSM encoding and default sizes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hpf_dp_arbiter_pkg;

    // Encodings are fixed so that other benches and logs decode the same state values.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_DELIVER = 2'd3
    } state_t;

    localparam int DEF_NUM_CH  = 8;
    localparam int DEF_WIDTH   = 16;
    localparam int DEF_TIMEOUT = 15;

    // Wait counter width; TIMEOUT is limited to 1..255.
    localparam int CNT_W = 8;

endpackage

// File: rtl/hpf_dp_arbiter_if.sv
// Bundles requester-side and datapath-side signals of the arbiter.
// Latency: n/a (wiring only).
// Backpressure: requesters hold req until their gnt pulse; the datapath is start/done.
interface hpf_dp_arbiter_if
    import hpf_dp_arbiter_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int WIDTH  = DEF_WIDTH
) ();
    localparam int CHW = $clog2(NUM_CH);

    logic [NUM_CH-1:0]       req;
    logic [NUM_CH*WIDTH-1:0] req_data;
    logic [NUM_CH-1:0]       gnt;
    logic                    dp_start;
    logic [WIDTH-1:0]        dp_din;
    logic [CHW-1:0]          dp_ch;
    logic                    dp_done;
    logic [WIDTH-1:0]        dp_dout;
    logic                    res_valid;
    logic [CHW-1:0]          res_ch;
    logic [WIDTH-1:0]        res_data;
    logic                    busy;
    logic                    timeout_err;

    // Arbiter view.
    modport master (
        input  req, req_data, dp_done, dp_dout,
        output gnt, dp_start, dp_din, dp_ch, res_valid, res_ch, res_data, busy, timeout_err
    );

    // Requester / datapath view.
    modport slave (
        output req, req_data, dp_done, dp_dout,
        input  gnt, dp_start, dp_din, dp_ch, res_valid, res_ch, res_data, busy, timeout_err
    );
endinterface

// File: rtl/hpf_dp_arbiter_pick.sv
// Round-robin pick: first set request at or after ptr, wrapping from N-1 to 0.
// Latency: combinational.
// Backpressure: none; any=0 when no request is set.
module rr_priority_pick #(
    parameter int N   = 8,
    parameter int CHW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [CHW-1:0] ptr,
    output logic           any,
    output logic [CHW-1:0] idx
);
    int pos;

    // Scan offsets 0..N-1 from ptr; the first hit is the winner.
    always_comb begin
        any = 1'b0;
        idx = '0;
        pos = 0;
        for (int i = 0; i < N; i++) begin
            pos = (int'(ptr) + i) % N;
            if (!any && req[pos]) begin
                any = 1'b1;
                idx = CHW'(pos);
            end
        end
    end
endmodule

// File: rtl/hpf_dp_arbiter.sv
// Shares one fixed-latency start/done filter datapath among NUM_CH channels, round-robin.
// Latency: req seen in IDLE -> gnt/dp_start next cycle; dp_done -> res_valid next cycle.
// Backpressure: one transaction in flight; req must be held until gnt; no res backpressure.
module hpf_dp_arbiter
    import hpf_dp_arbiter_pkg::*;
#(
    parameter int NUM_CH  = DEF_NUM_CH,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic          clk,
    input  logic          reset_n,
    hpf_dp_arbiter_if.master bus
);
    localparam int CHW = $clog2(NUM_CH);
    localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT);
    localparam logic [NUM_CH-1:0] ONE = NUM_CH'(1);

    state_t             state, state_nxt;
    logic [CHW-1:0]     sel, sel_nxt;
    logic [CHW-1:0]     rr_ptr, rr_ptr_nxt;
    logic [CNT_W-1:0]   wcnt, wcnt_nxt;

    logic [NUM_CH-1:0]  gnt_q, gnt_nxt;
    logic               start_q, start_nxt;
    logic [WIDTH-1:0]   din_q, din_nxt;
    logic [CHW-1:0]     ch_q, ch_nxt;
    logic               rvalid_q, rvalid_nxt;
    logic [CHW-1:0]     rch_q, rch_nxt;
    logic [WIDTH-1:0]   rdata_q, rdata_nxt;
    logic               busy_q, busy_nxt;
    logic               terr_q, terr_nxt;

    logic               pick_any;
    logic [CHW-1:0]     pick_idx;

    rr_priority_pick #(.N(NUM_CH), .CHW(CHW)) u_pick (
        .req (bus.req),
        .ptr (rr_ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    // Next-state and next-output logic; every output is registered from these values.
    always_comb begin
        state_nxt  = state;
        sel_nxt    = sel;
        rr_ptr_nxt = rr_ptr;
        wcnt_nxt   = wcnt;
        gnt_nxt    = '0;
        start_nxt  = 1'b0;
        din_nxt    = din_q;
        ch_nxt     = ch_q;
        rvalid_nxt = 1'b0;
        rch_nxt    = rch_q;
        rdata_nxt  = rdata_q;
        terr_nxt   = terr_q;
        case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    sel_nxt   = pick_idx;
                    din_nxt   = bus.req_data[int'(pick_idx)*WIDTH +: WIDTH];
                    ch_nxt    = pick_idx;
                    gnt_nxt   = ONE << pick_idx;
                    start_nxt = 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Winner drops to lowest priority; counter starts fresh for this transaction.
                rr_ptr_nxt = (int'(sel) == NUM_CH - 1) ? '0 : sel + 1'b1;
                wcnt_nxt   = '0;
                state_nxt  = ST_WAIT;
            end
            ST_WAIT: begin
                // A done arriving on the last allowed cycle still counts as success.
                if (bus.dp_done) begin
                    rvalid_nxt = 1'b1;
                    rch_nxt    = sel;
                    rdata_nxt  = bus.dp_dout;
                    state_nxt  = ST_DELIVER;
                end else if (wcnt + 1'b1 == TO_LIM) begin
                    terr_nxt  = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    wcnt_nxt = wcnt + 1'b1;
                end
            end
            ST_DELIVER: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        busy_nxt = (state_nxt != ST_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            sel      <= '0;
            rr_ptr   <= '0;
            wcnt     <= '0;
            gnt_q    <= '0;
            start_q  <= 1'b0;
            din_q    <= '0;
            ch_q     <= '0;
            rvalid_q <= 1'b0;
            rch_q    <= '0;
            rdata_q  <= '0;
            busy_q   <= 1'b0;
            terr_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            sel      <= sel_nxt;
            rr_ptr   <= rr_ptr_nxt;
            wcnt     <= wcnt_nxt;
            gnt_q    <= gnt_nxt;
            start_q  <= start_nxt;
            din_q    <= din_nxt;
            ch_q     <= ch_nxt;
            rvalid_q <= rvalid_nxt;
            rch_q    <= rch_nxt;
            rdata_q  <= rdata_nxt;
            busy_q   <= busy_nxt;
            terr_q   <= terr_nxt;
        end
    end

    assign bus.gnt         = gnt_q;
    assign bus.dp_start    = start_q;
    assign bus.dp_din      = din_q;
    assign bus.dp_ch       = ch_q;
    assign bus.res_valid   = rvalid_q;
    assign bus.res_ch      = rch_q;
    assign bus.res_data    = rdata_q;
    assign bus.busy        = busy_q;
    assign bus.timeout_err = terr_q;

endmodule

// File: tb/tb_hpf_dp_arbiter.sv
// Directed bench for hpf_dp_arbiter with a 3-cycle inverting datapath model.
// Latency: n/a.
// Backpressure: n/a.
module tb_hpf_dp_arbiter;
    logic clk = 1'b0;
    logic reset_n;

    hpf_dp_arbiter_if #(.NUM_CH(8), .WIDTH(16)) bus ();

    hpf_dp_arbiter #(.NUM_CH(8), .WIDTH(16), .TIMEOUT(15)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int lat;
    logic saw;
    logic dp_mute;
    logic inj_req;
    logic [15:0] inj_val;
    logic [15:0] dp_lat;
    int dp_cnt;
    logic [7:0] exp_gnt;

    // Datapath model: answers ~din three cycles after dp_start unless muted; inj_req forces a done.
    initial begin
        bus.dp_done = 1'b0;
        bus.dp_dout = '0;
        dp_cnt = 0;
        dp_lat = '0;
        forever begin
            @(negedge clk);
            if (inj_req === 1'b1) begin
                bus.dp_done = 1'b1;
                bus.dp_dout = inj_val;
            end else if (dp_cnt == 1) begin
                bus.dp_done = 1'b1;
                bus.dp_dout = dp_lat;
            end else begin
                bus.dp_done = 1'b0;
            end
            if (dp_cnt != 0) dp_cnt = dp_cnt - 1;
            if (bus.dp_start === 1'b1 && dp_mute !== 1'b1) begin
                dp_cnt = 3;
                dp_lat = ~bus.dp_din;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_gnt(output int l);
        l = 0;
        while (l < 40) begin
            @(negedge clk);
            l++;
            if (bus.gnt !== 8'h00) break;
        end
    endtask

    task automatic wait_res(output int l);
        l = 0;
        while (l < 40) begin
            @(negedge clk);
            l++;
            if (bus.res_valid === 1'b1) break;
        end
    endtask

    // One-cycle dp_done pulse driven by the model, launched away from the negedge.
    task automatic inject(input logic [15:0] v);
        @(posedge clk);
        #1;
        inj_val = v;
        inj_req = 1'b1;
        @(posedge clk);
        #1;
        inj_req = 1'b0;
        @(negedge clk);
    endtask

    // Directed sequence.
    initial begin
        reset_n = 1'b0;
        dp_mute = 1'b0;
        inj_req = 1'b0;
        inj_val = '0;
        bus.req = 8'hFF;
        bus.req_data = '0;
        for (int k = 0; k < 8; k++) bus.req_data[k*16 +: 16] = 16'h1000 + 16'(k);

        // Reset with all requests high.
        tick(3);
        chk("rst_gnt",   32'(bus.gnt), 32'h0);
        chk("rst_start", 32'(bus.dp_start), 32'h0);
        chk("rst_busy",  32'(bus.busy), 32'h0);
        chk("rst_rvld",  32'(bus.res_valid), 32'h0);
        chk("rst_terr",  32'(bus.timeout_err), 32'h0);
        chk("rst_rdata", 32'(bus.res_data), 32'h0);
        chk("rst_din",   32'(bus.dp_din), 32'h0);

        // Single request on ch3.
        bus.req = 8'h00;
        bus.req_data[3*16 +: 16] = 16'h00A5;
        reset_n = 1'b1;
        tick(2);
        chk("idle_busy", 32'(bus.busy), 32'h0);
        bus.req = 8'h08;
        wait_gnt(lat);
        bus.req = 8'h00;
        chk("s_gnt_lat", 32'(lat), 32'd1);
        chk("s_gnt",     32'(bus.gnt), 32'h08);
        chk("s_start",   32'(bus.dp_start), 32'h1);
        chk("s_din",     32'(bus.dp_din), 32'h00A5);
        chk("s_ch",      32'(bus.dp_ch), 32'd3);
        chk("s_busy",    32'(bus.busy), 32'h1);
        wait_res(lat);
        chk("s_res_lat", 32'(lat), 32'd4);
        chk("s_rvld",    32'(bus.res_valid), 32'h1);
        chk("s_rch",     32'(bus.res_ch), 32'd3);
        chk("s_rdata",   32'(bus.res_data), 32'hFF5A);
        tick(1);
        chk("s_rpulse",  32'(bus.res_valid), 32'h0);
        chk("s_rhold",   32'(bus.res_data), 32'hFF5A);
        chk("s_idle",    32'(bus.busy), 32'h0);

        // Fresh reset so round-robin starts at ch0, then all requests held.
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        bus.req_data[3*16 +: 16] = 16'h1003;
        bus.req = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            wait_gnt(lat);
            if (i == 8) bus.req = 8'h00;
            exp_gnt = 8'h01 << (i % 8);
            chk($sformatf("rr_gnt%0d", i), 32'(bus.gnt), 32'(exp_gnt));
            chk($sformatf("rr_din%0d", i), 32'(bus.dp_din), 32'h1000 + 32'(i % 8));
        end
        wait_res(lat);
        chk("rr_rch",   32'(bus.res_ch), 32'd0);
        chk("rr_rdata", 32'(bus.res_data), 32'hEFFF);
        tick(1);

        // Timeout: datapath never answers.
        dp_mute = 1'b1;
        bus.req = 8'h04;
        wait_gnt(lat);
        bus.req = 8'h00;
        chk("to_gnt", 32'(bus.gnt), 32'h04);
        saw = 1'b0;
        repeat (15) begin
            tick(1);
            if (bus.res_valid !== 1'b0) saw = 1'b1;
        end
        chk("to_nores",   32'(saw), 32'h0);
        chk("to_busy15",  32'(bus.busy), 32'h1);
        chk("to_terr15",  32'(bus.timeout_err), 32'h0);
        tick(1);
        chk("to_terr",    32'(bus.timeout_err), 32'h1);
        chk("to_idle",    32'(bus.busy), 32'h0);
        chk("to_rvld",    32'(bus.res_valid), 32'h0);
        inject(16'hBEEF);
        chk("late_rvld",  32'(bus.res_valid), 32'h0);
        chk("late_rdata", 32'(bus.res_data), 32'hEFFF);
        chk("late_busy",  32'(bus.busy), 32'h0);
        dp_mute = 1'b0;
        bus.req_data[0 +: 16] = 16'h0F0F;
        bus.req = 8'h01;
        wait_gnt(lat);
        bus.req = 8'h00;
        chk("post_gnt",   32'(bus.gnt), 32'h01);
        chk("post_din",   32'(bus.dp_din), 32'h0F0F);
        wait_res(lat);
        chk("post_rdata", 32'(bus.res_data), 32'hF0F0);
        chk("post_rch",   32'(bus.res_ch), 32'd0);
        chk("post_terr",  32'(bus.timeout_err), 32'h1);
        tick(1);

        // Reset while waiting on ch6.
        bus.req_data[6*16 +: 16] = 16'h6666;
        bus.req = 8'h40;
        wait_gnt(lat);
        bus.req = 8'h00;
        chk("mr_gnt", 32'(bus.gnt), 32'h40);
        tick(1);
        reset_n = 1'b0;
        tick(1);
        chk("mr_busy",  32'(bus.busy), 32'h0);
        chk("mr_terr",  32'(bus.timeout_err), 32'h0);
        chk("mr_rdata", 32'(bus.res_data), 32'h0);
        chk("mr_ch",    32'(bus.dp_ch), 32'h0);
        reset_n = 1'b1;
        saw = 1'b0;
        repeat (3) begin
            tick(1);
            if (bus.res_valid !== 1'b0) saw = 1'b1;
        end
        chk("mr_nores",  32'(saw), 32'h0);
        chk("mr_rhold",  32'(bus.res_data), 32'h0);
        bus.req_data[1*16 +: 16] = 16'h0011;
        bus.req_data[7*16 +: 16] = 16'h0077;
        bus.req = 8'h82;
        wait_gnt(lat);
        bus.req = 8'h00;
        chk("mr_ptr0",  32'(bus.gnt), 32'h02);
        wait_res(lat);
        chk("mr_rdata2", 32'(bus.res_data), 32'hFFEE);
        chk("mr_rch2",   32'(bus.res_ch), 32'd1);
        tick(1);

        // Spurious done while idle.
        inject(16'h1234);
        chk("sp_rvld",  32'(bus.res_valid), 32'h0);
        chk("sp_rdata", 32'(bus.res_data), 32'hFFEE);
        chk("sp_busy",  32'(bus.busy), 32'h0);

        // Done on the final allowed WAIT cycle wins over timeout.
        dp_mute = 1'b1;
        bus.req = 8'h10;
        wait_gnt(lat);
        bus.req = 8'h00;
        chk("dw_gnt", 32'(bus.gnt), 32'h10);
        tick(14);
        inject(16'h5A5A);
        chk("dw_rvld",  32'(bus.res_valid), 32'h1);
        chk("dw_rdata", 32'(bus.res_data), 32'h5A5A);
        chk("dw_rch",   32'(bus.res_ch), 32'd4);
        chk("dw_terr",  32'(bus.timeout_err), 32'h0);
        tick(1);
        chk("dw_idle",  32'(bus.busy), 32'h0);
        dp_mute = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Safety net in case a bounded wait is somehow bypassed.
    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion, required finish before 200000");
        $fatal(1, "watchdog");
    end
endmodule
